// File: rtl/s_axi_lite_regs.sv
// AXI4-Lite slave exposing a bank of read/write registers with per-register write strobes.
// Define S_AXI_LITE_REGS_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module s_axi_lite_regs #(
    parameter int unsigned P_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned P_S_AXI_ADDR_WIDTH = 6,
    parameter int unsigned P_NUM_REGS         = 8
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESETN,
    input  logic [P_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [P_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [P_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [P_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [P_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [P_NUM_REGS*P_S_AXI_DATA_WIDTH-1:0] o_regs,
    output logic [P_NUM_REGS-1:0]                    o_wr_pulse
);
    localparam int unsigned W       = P_S_AXI_DATA_WIDTH;
    localparam int unsigned StrbW   = W / 8;
    localparam int unsigned AddrLsb = $clog2(StrbW);
    localparam int unsigned IdxW    = P_S_AXI_ADDR_WIDTH - AddrLsb;
    localparam logic [1:0]  RespOkay = 2'b00;
`ifdef S_AXI_LITE_REGS_SLVERR_EN
    localparam logic [1:0]  RespOor  = 2'b10;
`else
    localparam logic [1:0]  RespOor  = 2'b00;
`endif

    logic                  init_q, init_d;
    logic                  aw_held_q, aw_held_d;
    logic [IdxW-1:0]       aw_idx_q, aw_idx_d;
    logic                  w_held_q, w_held_d;
    logic [W-1:0]          w_data_q, w_data_d;
    logic [StrbW-1:0]      w_strb_q, w_strb_d;
    logic                  wr_done_q, wr_done_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [P_NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
    logic [W-1:0]          regs_q [P_NUM_REGS];
    logic [W-1:0]          regs_d [P_NUM_REGS];
    logic                  rvalid_q, rvalid_d;
    logic [W-1:0]          rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;

    logic            aw_hs, w_hs, ar_hs, commit;
    logic [IdxW-1:0] ar_idx;
    logic            unused_inputs;

    // Readies stay low until the first edge after reset release.
    assign S_AXI_AWREADY = init_q && !aw_held_q && !bvalid_q;
    assign S_AXI_WREADY  = init_q && !w_held_q && !bvalid_q;
    assign S_AXI_ARREADY = init_q && !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign o_wr_pulse    = wr_pulse_q;

    assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
    assign ar_idx = S_AXI_ARADDR[P_S_AXI_ADDR_WIDTH-1:AddrLsb];
    // Held flags survive until the B handshake, so wr_done blocks a second commit.
    assign commit = aw_held_q && w_held_q && !wr_done_q;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[AddrLsb-1:0], S_AXI_ARADDR[AddrLsb-1:0]};

    for (genvar k = 0; k < P_NUM_REGS; k++) begin : g_out
        assign o_regs[k*W +: W] = regs_q[k];
    end

    always_comb begin
        init_d     = 1'b1;
        aw_held_d  = aw_held_q;
        aw_idx_d   = aw_idx_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        wr_done_d  = wr_done_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_idx_d  = S_AXI_AWADDR[P_S_AXI_ADDR_WIDTH-1:AddrLsb];
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end

        if (commit) begin
            wr_done_d = 1'b1;
            bresp_d   = RespOor;
            for (int k = 0; k < P_NUM_REGS; k++) begin
                if (aw_idx_q == IdxW'(k)) begin
                    bresp_d       = RespOkay;
                    wr_pulse_d[k] = 1'b1;
                    for (int b = 0; b < StrbW; b++) begin
                        if (w_strb_q[b]) regs_d[k][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end
        end

        if (wr_done_q && !bvalid_q) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d  = 1'b0;
            wr_done_d = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end

        // Reads sample regs_q, so a same-edge commit is not yet visible.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RespOor;
            for (int k = 0; k < P_NUM_REGS; k++) begin
                if (ar_idx == IdxW'(k)) begin
                    rdata_d = regs_q[k];
                    rresp_d = RespOkay;
                end
            end
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            init_q     <= 1'b0;
            aw_held_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            wr_done_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            wr_pulse_q <= '0;
            regs_q     <= '{default: '0};
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
        end else begin
            init_q     <= init_d;
            aw_held_q  <= aw_held_d;
            aw_idx_q   <= aw_idx_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            wr_done_q  <= wr_done_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

endmodule

// File: tb/tb_s_axi_lite_regs.sv
// Scoreboard bench for s_axi_lite_regs (32-bit data, 6-bit address, 8 registers).
// Honours S_AXI_LITE_REGS_SLVERR_EN for the expected out-of-range responses.
module tb_s_axi_lite_regs;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [5:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [255:0] o_regs;
    logic [7:0]   o_wr_pulse;

`ifdef S_AXI_LITE_REGS_SLVERR_EN
    localparam logic [1:0] OorResp = 2'b10;
`else
    localparam logic [1:0] OorResp = 2'b00;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model [8];
    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];

    s_axi_lite_regs dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .o_regs       (o_regs),
        .o_wr_pulse   (o_wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: pop on each B/R handshake (sampled mid-cycle, before the edge).
    always @(negedge clk) begin
        logic [1:0]  eb;
        logic [33:0] er;
        if (rst_n && bvalid && bready) begin
            check_eq("b_sb_nonempty", 64'(exp_b.size() > 0), 64'd1);
            if (exp_b.size() > 0) begin
                eb = exp_b.pop_front();
                check_eq("bresp", 64'(bresp), 64'(eb));
            end
        end
        if (rst_n && rvalid && rready) begin
            check_eq("r_sb_nonempty", 64'(exp_r.size() > 0), 64'd1);
            if (exp_r.size() > 0) begin
                er = exp_r.pop_front();
                check_eq("rdata", 64'(rdata), 64'(er[31:0]));
                check_eq("rresp", 64'(rresp), 64'(er[33:32]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge with the write channel idle.
    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input int b_hold);
        int          idx;
        logic        in_rng;
        logic [7:0]  exp_pulse;
        logic [31:0] nv;
        idx    = int'(addr[5:2]);
        in_rng = (idx < 8);
        exp_pulse = in_rng ? (8'd1 << idx) : 8'd0;
        check_eq("awready_idle", 64'(awready), 64'd1);
        check_eq("wready_idle", 64'(wready), 64'd1);
        bready = (b_hold == 0);
        wdata  = data;
        wstrb  = strb;
        wvalid = 1'b1;
        if (w_lead == 0) begin
            awaddr  = addr;
            awvalid = 1'b1;
        end
        step();
        wvalid = 1'b0;
        for (int i = 0; i < w_lead; i++) begin
            check_eq("wready_held", 64'(wready), 64'd0);
            check_eq("pulse_early", 64'(o_wr_pulse), 64'd0);
            if (i == w_lead - 1) begin
                awaddr  = addr;
                awvalid = 1'b1;
            end
            step();
        end
        awvalid = 1'b0;
        check_eq("awready_held", 64'(awready), 64'd0);
        check_eq("pulse_pre", 64'(o_wr_pulse), 64'd0);
        step();
        check_eq("pulse_commit", 64'(o_wr_pulse), 64'(exp_pulse));
        check_eq("bvalid_commit", 64'(bvalid), 64'd0);
        exp_b.push_back(in_rng ? 2'b00 : OorResp);
        if (in_rng) begin
            nv = model[idx];
            for (int b = 0; b < 4; b++) if (strb[b]) nv[8*b +: 8] = data[8*b +: 8];
            model[idx] = nv;
        end
        step();
        check_eq("bvalid_rise", 64'(bvalid), 64'd1);
        check_eq("pulse_after", 64'(o_wr_pulse), 64'd0);
        for (int i = 0; i < b_hold; i++) begin
            check_eq("bvalid_hold", 64'(bvalid), 64'd1);
            check_eq("bresp_hold", 64'(bresp), 64'(in_rng ? 2'b00 : OorResp));
            check_eq("awready_blk", 64'(awready), 64'd0);
            check_eq("wready_blk", 64'(wready), 64'd0);
            // A competing write must not be accepted while B is pending.
            awaddr  = 6'h00;
            awvalid = 1'b1;
            wdata   = 32'hFFFF_FFFF;
            wstrb   = 4'hF;
            wvalid  = 1'b1;
            step();
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        step();
        check_eq("bvalid_fall", 64'(bvalid), 64'd0);
        check_eq("awready_back", 64'(awready), 64'd1);
        check_eq("wready_back", 64'(wready), 64'd1);
    endtask

    task automatic axi_read(input logic [5:0] addr, input int r_hold);
        int          idx;
        logic [31:0] ed;
        logic [1:0]  ers;
        idx = int'(addr[5:2]);
        ed  = (idx < 8) ? model[idx] : 32'd0;
        ers = (idx < 8) ? 2'b00 : OorResp;
        check_eq("arready_idle", 64'(arready), 64'd1);
        araddr  = addr;
        arvalid = 1'b1;
        rready  = (r_hold == 0);
        exp_r.push_back({ers, ed});
        step();
        arvalid = 1'b0;
        check_eq("rvalid_lat1", 64'(rvalid), 64'd1);
        check_eq("arready_busy", 64'(arready), 64'd0);
        for (int i = 0; i < r_hold; i++) begin
            check_eq("rdata_hold", 64'(rdata), 64'(ed));
            check_eq("arready_hold", 64'(arready), 64'd0);
            step();
        end
        rready = 1'b1;
        step();
        check_eq("rvalid_fall", 64'(rvalid), 64'd0);
        check_eq("arready_back", 64'(arready), 64'd1);
    endtask

    initial begin
        logic [31:0] old0;
        for (int k = 0; k < 8; k++) model[k] = 32'd0;

        // Reset state
        #12;
        check_eq("rst_awready", 64'(awready), 64'd0);
        check_eq("rst_wready", 64'(wready), 64'd0);
        check_eq("rst_arready", 64'(arready), 64'd0);
        check_eq("rst_bvalid", 64'(bvalid), 64'd0);
        check_eq("rst_rvalid", 64'(rvalid), 64'd0);
        check_eq("rst_regs", 64'(o_regs != '0), 64'd0);
        check_eq("rst_pulse", 64'(o_wr_pulse), 64'd0);
        #4 rst_n = 1'b1;
        step();
        check_eq("rel_awready", 64'(awready), 64'd1);
        check_eq("rel_wready", 64'(wready), 64'd1);
        check_eq("rel_arready", 64'(arready), 64'd1);

        // Same-cycle AW/W, then read back
        axi_write(6'h04, 32'hDEAD_BEEF, 4'hF, 0, 0);
        axi_read(6'h04, 0);

        // W leads AW by three cycles, then a partial-strobe overwrite
        axi_write(6'h08, 32'h1122_3344, 4'hF, 3, 0);
        axi_write(6'h08, 32'hAAAA_5555, 4'h3, 0, 0);
        check_eq("reg2_value", 64'(o_regs[2*32 +: 32]), 64'h1122_5555);
        axi_read(6'h08, 0);

        // Back-pressured B with a blocked competing write
        axi_write(6'h0C, 32'hCAFE_F00D, 4'hF, 0, 5);
        check_eq("reg0_untouched", 64'(o_regs[31:0]), 64'(model[0]));
        axi_write(6'h00, 32'h0102_0304, 4'hF, 1, 0);

        // Read of reg0 handshaken on the commit edge of a write to reg0, then RREADY stall
        old0    = model[0];
        awaddr  = 6'h00;
        wdata   = 32'h55AA_55AA;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        step();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        araddr  = 6'h00;
        arvalid = 1'b1;
        rready  = 1'b0;
        exp_r.push_back({2'b00, old0});
        exp_b.push_back(2'b00);
        step();
        arvalid = 1'b0;
        model[0] = 32'h55AA_55AA;
        check_eq("pulse_collide", 64'(o_wr_pulse), 64'h01);
        check_eq("rvalid_collide", 64'(rvalid), 64'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq("rdata_old", 64'(rdata), 64'(old0));
            check_eq("arready_stall", 64'(arready), 64'd0);
            step();
        end
        rready = 1'b1;
        step();
        check_eq("rvalid_drop", 64'(rvalid), 64'd0);
        step();
        axi_read(6'h00, 0);

        // Out-of-range index 8
        axi_write(6'h20, 32'h9999_9999, 4'hF, 0, 0);
        axi_read(6'h20, 0);
        for (int k = 0; k < 8; k++) check_eq("oregs", 64'(o_regs[k*32 +: 32]), 64'(model[k]));

        // Reset mid-write after AW only
        awaddr  = 6'h0C;
        awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check_eq("aw_only_held", 64'(awready), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 8; k++) model[k] = 32'd0;
        check_eq("mid_awready", 64'(awready), 64'd0);
        check_eq("mid_wready", 64'(wready), 64'd0);
        check_eq("mid_arready", 64'(arready), 64'd0);
        check_eq("mid_bvalid", 64'(bvalid), 64'd0);
        check_eq("mid_bresp", 64'(bresp), 64'd0);
        check_eq("mid_rvalid", 64'(rvalid), 64'd0);
        check_eq("mid_rdata", 64'(rdata), 64'd0);
        check_eq("mid_rresp", 64'(rresp), 64'd0);
        check_eq("mid_regs", 64'(o_regs != '0), 64'd0);
        check_eq("mid_pulse", 64'(o_wr_pulse), 64'd0);
        step();
        #2 rst_n = 1'b1;
        step();
        check_eq("rel2_awready", 64'(awready), 64'd1);
        check_eq("rel2_wready", 64'(wready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check_eq("post_bvalid", 64'(bvalid), 64'd0);
            check_eq("post_pulse", 64'(o_wr_pulse), 64'd0);
            step();
        end
        check_eq("post_regs", 64'(o_regs != '0), 64'd0);
        axi_read(6'h04, 0);

        step();
        check_eq("sb_b_empty", 64'(exp_b.size()), 64'd0);
        check_eq("sb_r_empty", 64'(exp_r.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
